// File: rtl/pc_decode_unit_pkg.sv
`default_nettype none
// ============================================================================
// Module      : pc_decode_unit_pkg
// Description : Shared CPU definitions: opcodes, ALU operation encodings,
//               instruction field positions, FSM state type, and the
//               branch/jump offset helper.
// Revision    : 1.0 - initial release
// ============================================================================
package pc_decode_unit_pkg;

    // Opcodes, taken from INSTRUCTION[31:24]
    localparam logic [7:0] c_OP_LOADI = 8'h00;
    localparam logic [7:0] c_OP_MOV   = 8'h01;
    localparam logic [7:0] c_OP_ADD   = 8'h02;
    localparam logic [7:0] c_OP_SUB   = 8'h03;
    localparam logic [7:0] c_OP_AND   = 8'h04;
    localparam logic [7:0] c_OP_OR    = 8'h05;
    localparam logic [7:0] c_OP_J     = 8'h06;
    localparam logic [7:0] c_OP_BEQ   = 8'h07;

    // ALU operation encodings
    localparam logic [2:0] c_ALU_FWD = 3'b000;
    localparam logic [2:0] c_ALU_ADD = 3'b001;
    localparam logic [2:0] c_ALU_AND = 3'b010;
    localparam logic [2:0] c_ALU_OR  = 3'b011;

    // Instruction field bit positions
    localparam int c_OPC_MSB  = 31;
    localparam int c_OPC_LSB  = 24;
    localparam int c_DST_MSB  = 23;
    localparam int c_DST_LSB  = 16;
    localparam int c_SRC1_LSB = 8;
    localparam int c_SRC2_LSB = 0;

    // Default byte increment per instruction
    localparam int unsigned c_PC_STEP = 4;

    // Fetch/decode state machine
    typedef enum logic [1:0] {
        ST_BOOT  = 2'd0,
        ST_RUN   = 2'd1,
        ST_STALL = 2'd2,
        ST_HALT  = 2'd3
    } state_t;

    // Word offset to byte offset: sign-extend the 8-bit field, then scale by 4
    function automatic logic [31:0] f_branch_offset(input logic [7:0] i_off);
        return {{22{i_off[7]}}, i_off, 2'b00};
    endfunction

endpackage : pc_decode_unit_pkg
`default_nettype wire

// File: rtl/pc_decode_unit_if.sv
`default_nettype none
// ============================================================================
// Module      : pc_decode_unit_if
// Description : Bus between the fetch/decode stage and its neighbours
//               (instruction memory, ALU, register file).
//               master = decode unit, slave = surrounding datapath.
// Revision    : 1.0 - initial release
// ============================================================================
interface pc_decode_unit_if;
    logic [31:0] INSTRUCTION;
    logic        IMEM_BUSY;
    logic        ZERO;
    logic [31:0] PC;
    logic        WRITE;
    logic [2:0]  INADDRESS;
    logic [2:0]  OUT1ADDRESS;
    logic [2:0]  OUT2ADDRESS;
    logic [7:0]  IMMEDIATE;
    logic [2:0]  ALUOP;
    logic        IMM_SEL;
    logic        NEG_SEL;
    logic        HALTED;

    modport master (
        input  INSTRUCTION, IMEM_BUSY, ZERO,
        output PC, WRITE, INADDRESS, OUT1ADDRESS, OUT2ADDRESS,
               IMMEDIATE, ALUOP, IMM_SEL, NEG_SEL, HALTED
    );

    modport slave (
        output INSTRUCTION, IMEM_BUSY, ZERO,
        input  PC, WRITE, INADDRESS, OUT1ADDRESS, OUT2ADDRESS,
               IMMEDIATE, ALUOP, IMM_SEL, NEG_SEL, HALTED
    );
endinterface : pc_decode_unit_if
`default_nettype wire

// File: rtl/pc_decode_unit_control_decoder.sv
`default_nettype none
// ============================================================================
// Module      : pc_decode_unit_control_decoder
// Description : Purely combinational opcode decoder producing register-file
//               write enable, ALU operation, operand selects and an
//               illegal-opcode flag.
// Revision    : 1.0 - initial release
// ============================================================================
module pc_decode_unit_control_decoder
    import pc_decode_unit_pkg::*;
(
    input  wire logic [7:0] i_opcode,
    output logic            o_write,
    output logic [2:0]      o_aluop,
    output logic            o_imm_sel,
    output logic            o_neg_sel,
    output logic            o_illegal
);

    // Opcode lookup; unknown opcodes decode as a harmless no-op flagged illegal
    always_comb begin
        o_write   = 1'b0;
        o_aluop   = c_ALU_FWD;
        o_imm_sel = 1'b0;
        o_neg_sel = 1'b0;
        o_illegal = 1'b0;
        case (i_opcode)
            c_OP_LOADI: begin o_write = 1'b1; o_imm_sel = 1'b1;                 end
            c_OP_MOV:   begin o_write = 1'b1;                                   end
            c_OP_ADD:   begin o_write = 1'b1; o_aluop = c_ALU_ADD;              end
            c_OP_SUB:   begin o_write = 1'b1; o_aluop = c_ALU_ADD; o_neg_sel = 1'b1; end
            c_OP_AND:   begin o_write = 1'b1; o_aluop = c_ALU_AND;              end
            c_OP_OR:    begin o_write = 1'b1; o_aluop = c_ALU_OR;               end
            c_OP_J:     begin                                                   end
            c_OP_BEQ:   begin o_aluop = c_ALU_ADD; o_neg_sel = 1'b1;            end
            default:    begin o_illegal = 1'b1;                                 end
        endcase
    end

endmodule : pc_decode_unit_control_decoder
`default_nettype wire

// File: rtl/pc_decode_unit.sv
`default_nettype none
// ============================================================================
// Module      : pc_decode_unit
// Description : Fetch/decode stage: 32-bit PC register, next-PC selection
//               (sequential / jump / branch-if-equal), instruction field
//               decode and a BOOT/RUN/STALL/HALT control FSM.
// Revision    : 1.0 - initial release
// ============================================================================
module pc_decode_unit
    import pc_decode_unit_pkg::*;
#(
    parameter logic [31:0] PC_RESET = 32'h0000_0000,
    parameter int unsigned PC_STEP  = c_PC_STEP
) (
    input  wire logic          CLK,
    input  wire logic          RESET,
    pc_decode_unit_if.master   bus
);

    state_t      r_state;
    logic [31:0] r_pc;
    logic        r_halted;

    logic [7:0]  w_opcode;
    logic [7:0]  w_offset_field;
    logic        w_dec_write;
    logic [2:0]  w_dec_aluop;
    logic        w_dec_imm_sel;
    logic        w_dec_neg_sel;
    logic        w_dec_illegal;
    logic        w_executing;
    logic        w_take;
    logic [31:0] w_pc_seq;
    logic [31:0] w_pc_target;
    logic [31:0] w_pc_next;
    logic [4:0]  w_unused_bits;

    assign w_opcode       = bus.INSTRUCTION[c_OPC_MSB:c_OPC_LSB];
    assign w_offset_field = bus.INSTRUCTION[c_DST_MSB:c_DST_LSB];
    // Bits between the source-1 field and the offset field are not decoded
    assign w_unused_bits  = bus.INSTRUCTION[15:11];

    pc_decode_unit_control_decoder u_control_decoder (
        .i_opcode  (w_opcode),
        .o_write   (w_dec_write),
        .o_aluop   (w_dec_aluop),
        .o_imm_sel (w_dec_imm_sel),
        .o_neg_sel (w_dec_neg_sel),
        .o_illegal (w_dec_illegal)
    );

    // An instruction is consumed only when out of reset, in RUN/STALL, and memory is ready
    assign w_executing = RESET && !bus.IMEM_BUSY &&
                         ((r_state == ST_RUN) || (r_state == ST_STALL));

    // Next-PC: jumps always take the target, beq only when the ALU reports zero
    assign w_pc_seq    = r_pc + 32'(PC_STEP);
    assign w_pc_target = w_pc_seq + f_branch_offset(w_offset_field);
    assign w_take      = (w_opcode == c_OP_J) || ((w_opcode == c_OP_BEQ) && bus.ZERO);
    assign w_pc_next   = w_take ? w_pc_target : w_pc_seq;

    // Raw field slices are passed straight through in every state
    assign bus.INADDRESS   = bus.INSTRUCTION[c_DST_LSB+2:c_DST_LSB];
    assign bus.OUT1ADDRESS = bus.INSTRUCTION[c_SRC1_LSB+2:c_SRC1_LSB];
    assign bus.OUT2ADDRESS = bus.INSTRUCTION[c_SRC2_LSB+2:c_SRC2_LSB];
    assign bus.IMMEDIATE   = bus.INSTRUCTION[7:0];

    // Write enable gated so the register file never writes while it is being cleared or idle
    assign bus.WRITE   = w_executing && w_dec_write;
    // ALU controls read as zero while reset is held
    assign bus.ALUOP   = RESET ? w_dec_aluop   : c_ALU_FWD;
    assign bus.IMM_SEL = RESET ? w_dec_imm_sel : 1'b0;
    assign bus.NEG_SEL = RESET ? w_dec_neg_sel : 1'b0;

    assign bus.PC     = r_pc;
    assign bus.HALTED = r_halted;

    // Control FSM with PC register; reset overrides stall, halt and branch events
    always_ff @(posedge CLK) begin
        if (!RESET) begin
            r_state  <= ST_BOOT;
            r_pc     <= PC_RESET;
            r_halted <= 1'b0;
        end else begin
            case (r_state)
                ST_BOOT: begin
                    r_state <= ST_RUN;
                end
                ST_RUN, ST_STALL: begin
                    if (bus.IMEM_BUSY) begin
                        r_state <= ST_STALL;
                    end else if (w_dec_illegal) begin
                        r_state  <= ST_HALT;
                        r_halted <= 1'b1;
                    end else begin
                        r_state <= ST_RUN;
                        r_pc    <= w_pc_next;
                    end
                end
                ST_HALT: begin
                    r_state <= ST_HALT;
                end
                default: begin
                    r_state <= ST_BOOT;
                end
            endcase
        end
    end

endmodule : pc_decode_unit
`default_nettype wire

// File: tb/tb_pc_decode_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_pc_decode_unit
// Description : Directed self-checking bench for pc_decode_unit, including a
//               second instance started near the top of the address space.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pc_decode_unit;

    logic CLK;
    logic RESET;
    int   n_total;
    int   n_pass;

    pc_decode_unit_if bus ();
    pc_decode_unit_if bus_w ();

    pc_decode_unit #(.PC_RESET(32'h0000_0000), .PC_STEP(4)) dut (
        .CLK   (CLK),
        .RESET (RESET),
        .bus   (bus)
    );

    pc_decode_unit #(.PC_RESET(32'hFFFF_FFFC), .PC_STEP(4)) dut_wrap (
        .CLK   (CLK),
        .RESET (RESET),
        .bus   (bus_w)
    );

    initial CLK = 1'b0;
    always #4 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    // Advance one rising edge, then move 2 units away from it
    task automatic tick();
        @(posedge CLK);
        #2;
    endtask

    initial begin
        n_total = 0;
        n_pass  = 0;
        RESET = 1'b0;
        bus.INSTRUCTION = 32'h0002_0005;   // loadi r2,0x05
        bus.IMEM_BUSY   = 1'b0;
        bus.ZERO        = 1'b0;
        bus_w.INSTRUCTION = 32'h0002_0005;
        bus_w.IMEM_BUSY   = 1'b0;
        bus_w.ZERO        = 1'b0;

        // Reset held for two edges
        #1;
        chk("rst_write", 32'(bus.WRITE), 32'd0);
        chk("rst_imm_sel", 32'(bus.IMM_SEL), 32'd0);
        tick();
        tick();
        chk("rst_pc", bus.PC, 32'h0);
        chk("rst_halted", 32'(bus.HALTED), 32'd0);
        chk("rst_aluop", 32'(bus.ALUOP), 32'd0);
        chk("rst_neg_sel", 32'(bus.NEG_SEL), 32'd0);

        // BOOT: no write, PC held
        RESET = 1'b1;
        #1;
        chk("boot_write", 32'(bus.WRITE), 32'd0);
        tick();
        chk("boot_pc", bus.PC, 32'h0);
        chk("wrap_start_pc", bus_w.PC, 32'hFFFF_FFFC);

        // RUN: loadi r2,0x05
        chk("loadi_write", 32'(bus.WRITE), 32'd1);
        chk("loadi_inaddr", 32'(bus.INADDRESS), 32'd2);
        chk("loadi_imm_sel", 32'(bus.IMM_SEL), 32'd1);
        chk("loadi_aluop", 32'(bus.ALUOP), 32'd0);
        chk("loadi_imm", 32'(bus.IMMEDIATE), 32'h05);
        tick();
        chk("pc_after_loadi", bus.PC, 32'h4);
        chk("wrap_pc", bus_w.PC, 32'h0);

        // add r3,r1,r2
        bus.INSTRUCTION = 32'h0203_0102;
        #1;
        chk("add_aluop", 32'(bus.ALUOP), 32'd1);
        chk("add_out1", 32'(bus.OUT1ADDRESS), 32'd1);
        chk("add_out2", 32'(bus.OUT2ADDRESS), 32'd2);
        chk("add_write", 32'(bus.WRITE), 32'd1);
        chk("add_imm_sel", 32'(bus.IMM_SEL), 32'd0);
        tick();
        chk("pc_after_add", bus.PC, 32'h8);

        // Instruction memory stall for 3 cycles at PC=0x08
        bus.IMEM_BUSY = 1'b1;
        #1;
        chk("stall_write0", 32'(bus.WRITE), 32'd0);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("stall_pc", bus.PC, 32'h8);
            chk("stall_write", 32'(bus.WRITE), 32'd0);
        end
        bus.IMEM_BUSY = 1'b0;
        tick();
        chk("pc_after_stall", bus.PC, 32'hC);

        // sub r1,r1,r2 to step to 0x10
        bus.INSTRUCTION = 32'h0301_0102;
        #1;
        chk("sub_neg_sel", 32'(bus.NEG_SEL), 32'd1);
        chk("sub_aluop", 32'(bus.ALUOP), 32'd1);
        tick();
        chk("pc_after_sub", bus.PC, 32'h10);

        // j -2 at 0x10 -> 0x0C
        bus.INSTRUCTION = 32'h06FE_0000;
        #1;
        chk("j_write", 32'(bus.WRITE), 32'd0);
        tick();
        chk("pc_after_j", bus.PC, 32'hC);

        // beq +2 with ZERO=1 at 0x0C -> 0x18
        bus.INSTRUCTION = 32'h0702_0000;
        bus.ZERO = 1'b1;
        #1;
        chk("beq_neg_sel", 32'(bus.NEG_SEL), 32'd1);
        chk("beq_write", 32'(bus.WRITE), 32'd0);
        tick();
        chk("pc_beq_taken", bus.PC, 32'h18);

        // j -4 at 0x18 -> 0x0C
        bus.INSTRUCTION = 32'h06FC_0000;
        bus.ZERO = 1'b0;
        tick();
        chk("pc_after_jback", bus.PC, 32'hC);

        // beq +2 with ZERO=0 at 0x0C -> 0x10
        bus.INSTRUCTION = 32'h0702_0000;
        tick();
        chk("pc_beq_not_taken", bus.PC, 32'h10);

        // beq during a stall: ZERO=1 while busy is ignored, ZERO=0 on release
        bus.IMEM_BUSY = 1'b1;
        bus.ZERO = 1'b1;
        tick();
        chk("beq_stall_pc", bus.PC, 32'h10);
        bus.IMEM_BUSY = 1'b0;
        bus.ZERO = 1'b0;
        tick();
        chk("beq_stall_release_pc", bus.PC, 32'h14);

        // j +2 at 0x14 -> 0x20
        bus.INSTRUCTION = 32'h0602_0000;
        tick();
        chk("pc_at_0x20", bus.PC, 32'h20);

        // Illegal opcode 0xFF halts
        bus.INSTRUCTION = 32'hFF00_0000;
        #1;
        chk("illegal_write", 32'(bus.WRITE), 32'd0);
        tick();
        bus.INSTRUCTION = 32'h0002_0005;
        for (int i = 0; i < 10; i++) begin
            chk("halt_halted", 32'(bus.HALTED), 32'd1);
            chk("halt_pc", bus.PC, 32'h20);
            chk("halt_write", 32'(bus.WRITE), 32'd0);
            tick();
        end

        // Reset out of HALT, with memory busy
        RESET = 1'b0;
        bus.IMEM_BUSY = 1'b1;
        tick();
        chk("halt_rst_pc", bus.PC, 32'h0);
        chk("halt_rst_halted", 32'(bus.HALTED), 32'd0);
        RESET = 1'b1;
        bus.IMEM_BUSY = 1'b0;
        tick();
        chk("reboot_pc", bus.PC, 32'h0);
        tick();
        chk("reboot_first_inc", bus.PC, 32'h4);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    // Hard time limit so the bench always terminates
    initial begin
        #20000;
        $display("FAIL timeout: simulation did not reach the summary");
        $fatal(1, "timeout");
    end

endmodule : tb_pc_decode_unit
`default_nettype wire
